// File: rtl/dmem_bridge_if.sv
// Bus side of the data-memory bridge: request/handshake signals toward the memory slave.
interface dmem_bridge_if;
    logic        bus_valid;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ready,
        output bus_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns a core load/store into a single bus transaction with
// wait-state tolerance, a timeout abort and a sticky error flag.
//
// state | meaning
// IDLE  | waiting for memread/memwrite; misaligned requests only raise err
// BUSY  | bus_valid high, waiting for bus_ready or timeout
// DONE  | result visible to the core for one cycle, stall released
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   readdata,
    output logic          stall,
    output logic          err,
    dmem_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Abort happens on the edge that would bring the count up to TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] rdata_q;
    logic        req;
    logic        aligned;
    logic        misaligned_now;

    assign req            = memread | memwrite;
    assign aligned        = (addr[1:0] == 2'b00);
    assign misaligned_now = (state == IDLE) && req && !aligned;

    // Stall must rise in the request cycle itself, so it is decoded, not registered;
    // gating with reset keeps it low while reset holds the FSM in IDLE.
    assign stall    = reset & (((state == IDLE) && req && aligned) || (state == BUSY));
    assign readdata = misaligned_now ? 32'h0 : rdata_q;

    // Transaction FSM with registered bus outputs, wait counter and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            rdata_q       <= 32'h0;
            err           <= 1'b0;
            bus.bus_valid <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 30'h0;
            bus.bus_wdata <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        if (aligned) begin
                            state         <= BUSY;
                            wait_cnt      <= 8'd0;
                            bus.bus_valid <= 1'b1;
                            bus.bus_we    <= memwrite;
                            bus.bus_addr  <= addr[31:2];
                            bus.bus_wdata <= wdata;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.bus_ready) begin
                        // A ready on the timeout edge still wins as a clean handshake.
                        bus.bus_valid <= 1'b0;
                        state         <= DONE;
                        if (!bus.bus_we) begin
                            rdata_q <= bus.bus_rdata;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt      <= wait_cnt + 8'd1;
                        bus.bus_valid <= 1'b0;
                        err           <= 1'b1;
                        state         <= DONE;
                        if (!bus.bus_we) begin
                            rdata_q <= 32'h0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum number of BUSY cycles waited for bus_ready before the access is aborted (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 memread  input  1  core requests a word load this instruction.
REQ-005 memwrite  input  1  core requests a word store this instruction.
REQ-006 addr  input  32  byte address from the core ALU result.
REQ-007 wdata  input  32  store data from the core register file port B.
REQ-008 readdata  output  32  load data returned to the core result mux.
REQ-009 stall  output  1  1 = core must hold PC and all state this cycle.
REQ-010 err  output  1  sticky error flag.
REQ-011 bus_valid  output  1  bus request valid.
REQ-012 bus_we  output  1  1 = write, 0 = read.
REQ-013 bus_addr  output  30  word address, equal to addr[31:2].
REQ-014 bus_wdata  output  32  store data.
REQ-015 bus_ready  input  1  slave accepts/completes the transfer; bus_rdata is valid in the same cycle.
REQ-016 bus_rdata  input  32  read data.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY and DONE, encoded in registers.
REQ-018 An access SHALL be requested when memread|memwrite = 1 in IDLE; if both are high, the access SHALL be a write.
REQ-019 In IDLE with a request and addr[1:0] = 00, stall SHALL be 1 combinationally in the same cycle, and the next edge SHALL capture addr[31:2], wdata and the write flag into the bus registers and enter BUSY.
REQ-020 In IDLE with a request and addr[1:0] != 00 (misaligned), the block SHALL issue no bus access, keep stall at 0, set err at the next edge, and drive readdata to 0 for that cycle.
REQ-021 In BUSY, bus_valid SHALL be 1, and bus_we/bus_addr/bus_wdata SHALL remain stable until the handshake or abort.
REQ-022 In BUSY, stall SHALL be 1.
REQ-023 The handshake SHALL complete on the edge where bus_valid = 1 and bus_ready = 1; a read SHALL capture bus_rdata into the readdata register on that edge, and the FSM SHALL then enter DONE.
REQ-024 Minimum latency SHALL be 3 cycles (IDLE, BUSY with ready, DONE), and the core SHALL advance at the end of DONE.
REQ-025 In DONE, stall SHALL be 0 and bus_valid SHALL be 0; the next state SHALL be IDLE unconditionally, so a request still present in DONE is not reissued.
REQ-026 A wait counter SHALL clear on IDLE->BUSY and increment on each BUSY cycle without bus_ready.
REQ-027 When the wait counter reaches TIMEOUT, the block SHALL deassert bus_valid, set err, load readdata with 0 (reads only), and enter DONE.
REQ-028 bus_ready arriving on the same edge as the timeout SHALL count as a completed handshake, with no error.
REQ-029 Outside DONE and misaligned cycles, readdata SHALL hold its last captured value; a write SHALL not modify readdata.
REQ-030 Once set, err SHALL remain 1 until reset.
REQ-031 bus_ready or bus_rdata activity while not in BUSY SHALL be ignored.

Reset
REQ-032 While reset = 0, the block SHALL hold: state IDLE, bus_valid 0, bus_we 0, bus_addr 0, bus_wdata 0, readdata 0, err 0, wait counter 0, and stall forced to 0.
REQ-033 Reset asserted mid-BUSY SHALL drop bus_valid asynchronously and abandon the transfer, with no completion and no error.
REQ-034 After reset deasserts, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-035 Aligned load: memread = 1, addr = 0x0000_0044, bus_ready high on the first BUSY cycle with bus_rdata = 0xCAFE_F00D -> bus_addr = 0x11; stall = 1,1,0 over 3 cycles; readdata = 0xCAFE_F00D in DONE; err = 0.
REQ-036 Store with 4 wait states: memwrite = 1, addr = 0x80, wdata = 0x1234_5678, bus_ready on the 5th BUSY cycle -> bus_we = 1 and address/data stable throughout BUSY; stall high for 6 cycles; readdata unchanged.
REQ-037 Misaligned load: memread = 1, addr = 0x0000_0046 -> bus_valid never asserted; stall = 0; readdata = 0; err = 1 on the next edge and it stays 1.
REQ-038 Timeout with TIMEOUT = 4: load with bus_ready held 0 -> bus_valid drops after 4 BUSY cycles; DONE follows with readdata = 0 and err = 1. Repeat the run with bus_ready arriving exactly on the 4th BUSY cycle -> normal completion with err = 0.
REQ-039 Reset in BUSY: reset = 0 on the second BUSY cycle -> bus_valid = 0 and stall = 0 immediately; all registers read 0; a fresh load after release completes normally.
REQ-040 Simultaneous memread = 1 and memwrite = 1 at addr = 0x10 -> a single write transaction (bus_we = 1), and no read capture into readdata.
